// File: rtl/sft_calc_core_pkg.sv
// Shared constants, FSM state encoding and operand/result coding helpers
// for the byte-serial 4-bit calculator core.
package sft_calc_core_pkg;

    localparam logic [7:0] ASCII_PLUS    = 8'h2B;
    localparam logic [7:0] ASCII_LO_BASE = 8'h30;
    localparam logic [7:0] ASCII_HI_BASE = 8'h50;

    typedef enum logic [1:0] {
        S_OP1 = 2'd0,
        S_OP2 = 2'd1,
        S_OPR = 2'd2
    } state_e;

    // Only the low nibble of a decoded operand reaches the arithmetic, so the
    // 0x5X range flag is dropped here; bytes outside both ranges decode to zero.
    function automatic logic [3:0] operand_nibble(input logic [7:0] b);
        logic [3:0] nib;
        if ((b[7:4] == ASCII_LO_BASE[7:4]) || (b[7:4] == ASCII_HI_BASE[7:4])) begin
            nib = b[3:0];
        end else begin
            nib = 4'h0;
        end
        return nib;
    endfunction

    function automatic logic [7:0] encode_result(input logic [4:0] res);
        logic [7:0] code;
        if (res[4]) begin
            code = ASCII_HI_BASE + {4'h0, res[3:0]};
        end else begin
            code = ASCII_LO_BASE + {4'h0, res[3:0]};
        end
        return code;
    endfunction

endpackage

// File: rtl/sft_calc_alu.sv
// Combinational datapath: decodes both operand bytes, adds or subtracts
// according to the operator byte and ASCII-encodes the 5-bit result.
module sft_calc_alu
    import sft_calc_core_pkg::*;
(
    input  logic [7:0] op1_i,
    input  logic [7:0] op2_i,
    input  logic [7:0] opr_i,
    output logic [4:0] res_o,
    output logic [7:0] ascii_o
);

    logic [3:0] a_s;
    logic [3:0] b_s;

    // Any operator other than '+' subtracts; bit 4 is carry or borrow.
    always_comb begin
        a_s = operand_nibble(op1_i);
        b_s = operand_nibble(op2_i);
        if (opr_i == ASCII_PLUS) begin
            res_o = {1'b0, a_s} + {1'b0, b_s};
        end else begin
            res_o = {1'b0, a_s} - {1'b0, b_s};
        end
        ascii_o = encode_result(res_o);
    end

endmodule

// File: rtl/sft_calc_core.sv
// Calculator core: collects op1/op2/operator bytes, echoes operands and
// returns the ASCII result one cycle after each accepted byte.
module sft_calc_core
    import sft_calc_core_pkg::*;
#(
    parameter bit ECHO_OPERANDS = 1'b1
) (
    input  logic       clk12m,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_rdy,
    output logic [7:0] tx_data,
    output logic       tx_data_rdy,
    output logic [4:0] leds
);

    state_e     state_q;
    logic [7:0] op1_q;
    logic [7:0] op2_q;
    logic [7:0] tx_data_q;
    logic       tx_rdy_q;
    logic [4:0] leds_q;
    logic [4:0] alu_res_s;
    logic [7:0] alu_ascii_s;

    // The operator is evaluated straight off rx_data in the cycle it arrives.
    sft_calc_alu u_alu (
        .op1_i   (op1_q),
        .op2_i   (op2_q),
        .opr_i   (rx_data),
        .res_o   (alu_res_s),
        .ascii_o (alu_ascii_s)
    );

    // Command FSM with registered transmit strobe, data and LED outputs.
    always_ff @(posedge clk12m or posedge rst) begin
        if (rst) begin
            state_q   <= S_OP1;
            op1_q     <= 8'h00;
            op2_q     <= 8'h00;
            tx_data_q <= 8'h00;
            tx_rdy_q  <= 1'b0;
            leds_q    <= 5'b00000;
        end else begin
            tx_rdy_q <= 1'b0;
            if (rx_data_rdy) begin
                case (state_q)
                    S_OP1: begin
                        op1_q <= rx_data;
                        if (ECHO_OPERANDS) begin
                            tx_data_q <= rx_data;
                            tx_rdy_q  <= 1'b1;
                        end
                        state_q <= S_OP2;
                    end
                    S_OP2: begin
                        op2_q <= rx_data;
                        if (ECHO_OPERANDS) begin
                            tx_data_q <= rx_data;
                            tx_rdy_q  <= 1'b1;
                        end
                        state_q <= S_OPR;
                    end
                    S_OPR: begin
                        tx_data_q <= alu_ascii_s;
                        tx_rdy_q  <= 1'b1;
                        leds_q    <= alu_res_s;
                        state_q   <= S_OP1;
                    end
                    default: begin
                        state_q <= S_OP1;
                    end
                endcase
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_data_rdy = tx_rdy_q;
    assign leds        = leds_q;

endmodule

// File: tb/tb_sft_calc_core.sv
// Directed testbench for sft_calc_core with a command-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_sft_calc_core;

    logic       clk12m = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_rdy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_data_rdy;
    logic [4:0] leds;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic       exp_rdy  = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic [4:0] exp_leds = 5'b00000;
    int         m_idx    = 0;
    logic [7:0] m_op1    = 8'h00;
    logic [7:0] m_op2    = 8'h00;

    logic [7:0] txlog[$];
    int         txcyc[$];

    sft_calc_core #(.ECHO_OPERANDS(1'b1)) dut (
        .clk12m      (clk12m),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .tx_data     (tx_data),
        .tx_data_rdy (tx_data_rdy),
        .leds        (leds)
    );

    always #5 clk12m = ~clk12m;

    always @(posedge clk12m) cyc <= cyc + 1;

    function automatic int operand_value(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h3F) return int'(b) - 48;
        if (b >= 8'h50 && b <= 8'h5F) return int'(b) - 80;
        return 0;
    endfunction

    function automatic int model_result(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        int x;
        int y;
        x = operand_value(a) % 16;
        y = operand_value(b) % 16;
        if (op == 8'h2B) return x + y;
        return (x - y + 32) % 32;
    endfunction

    function automatic logic [7:0] model_ascii(input int r);
        if (r >= 16) return 8'(80 + r - 16);
        return 8'(48 + r);
    endfunction

    // Reference model: one tx strobe per accepted byte, result on every third byte.
    always @(posedge clk12m or posedge rst) begin
        if (rst) begin
            m_idx    <= 0;
            exp_rdy  <= 1'b0;
            exp_data <= 8'h00;
            exp_leds <= 5'b00000;
        end else begin
            exp_rdy <= 1'b0;
            if (rx_data_rdy) begin
                if (m_idx == 0) begin
                    m_op1 <= rx_data;
                    exp_rdy <= 1'b1;
                    exp_data <= rx_data;
                    m_idx <= 1;
                end else if (m_idx == 1) begin
                    m_op2 <= rx_data;
                    exp_rdy <= 1'b1;
                    exp_data <= rx_data;
                    m_idx <= 2;
                end else begin
                    exp_rdy <= 1'b1;
                    exp_data <= model_ascii(model_result(m_op1, m_op2, rx_data));
                    exp_leds <= 5'(model_result(m_op1, m_op2, rx_data));
                    m_idx <= 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, and strobe logging.
    always @(negedge clk12m) begin
        n_checks++;
        if (tx_data_rdy === exp_rdy && tx_data === exp_data && leds === exp_leds) begin
            n_pass++;
        end else begin
            $display("FAIL model_cycle%0d: got rdy=%b data=%h leds=%b, want rdy=%b data=%h leds=%b",
                     cyc, tx_data_rdy, tx_data, leds, exp_rdy, exp_data, exp_leds);
        end
        if (tx_data_rdy === 1'b1) begin
            txlog.push_back(tx_data);
            txcyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_data_rdy = 1'b1;
        @(posedge clk12m);
        #2;
        rx_data_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_data_rdy = 1'b0;
        repeat (n) begin
            @(posedge clk12m);
            #2;
        end
    endtask

    task automatic check_log(input string name, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        check({name, "_count"}, txlog.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < txlog.size()) check($sformatf("%s_tx%0d", name, i), txlog[i], e[i]);
            else check($sformatf("%s_tx%0d_missing", name, i), 0, 1);
        end
    endtask

    task automatic clear_log();
        txlog.delete();
        txcyc.delete();
    endtask

    initial begin
        idle(2);
        check("reset_leds", leds, 5'b00000);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_tx_rdy", tx_data_rdy, 0);
        rst = 1'b0;
        idle(2);

        put(8'h30); idle(1); put(8'h34); idle(1); put(8'h2B); idle(2);
        check_log("add_0_4", 8'h30, 8'h34, 8'h34);
        check("add_0_4_leds", leds, 5'b00100);
        check("add_0_4_model_leds", exp_leds, 5'b00100);
        clear_log();

        put(8'h35); idle(1); put(8'h32); idle(1); put(8'h2D); idle(2);
        check_log("sub_5_2", 8'h35, 8'h32, 8'h33);
        check("sub_5_2_leds", leds, 5'b00011);
        clear_log();

        put(8'h32); idle(1); put(8'h33); idle(1); put(8'h2D); idle(2);
        check_log("sub_borrow", 8'h32, 8'h33, 8'h5F);
        check("sub_borrow_leds", leds, 5'b11111);
        check("sub_borrow_model_leds", exp_leds, 5'b11111);
        clear_log();

        put(8'h3F); put(8'h31); put(8'h2B); idle(2);
        check_log("b2b_carry", 8'h3F, 8'h31, 8'h50);
        check("b2b_carry_leds", leds, 5'b10000);
        if (txcyc.size() == 3) begin
            check("b2b_consecutive_1", txcyc[1] - txcyc[0], 1);
            check("b2b_consecutive_2", txcyc[2] - txcyc[1], 1);
        end else begin
            check("b2b_strobe_count", txcyc.size(), 3);
        end
        clear_log();

        put(8'h37); idle(1); put(8'h41); idle(1); put(8'h2A); idle(2);
        check_log("invalid_op", 8'h37, 8'h41, 8'h37);
        check("invalid_op_leds", leds, 5'b00111);
        clear_log();

        put(8'h39); put(8'h33); idle(1);
        check("partial_echo_count", txlog.size(), 2);
        clear_log();
        rst = 1'b1;
        #1;
        check("async_reset_leds", leds, 5'b00000);
        check("async_reset_state_tx", tx_data, 8'h00);
        idle(2);
        check("in_reset_leds", leds, 5'b00000);
        rst = 1'b0;
        idle(3);
        check("post_reset_silent", txlog.size(), 0);
        put(8'h31); idle(1); put(8'h31); idle(1); put(8'h2B); idle(2);
        check_log("after_reset", 8'h31, 8'h31, 8'h32);
        check("after_reset_leds", leds, 5'b00010);
        clear_log();

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
